key_debounce2: RTL and testbench

Two-channel push-button conditioner that turns raw, asynchronous, bouncing active-low key inputs into clean, synchronous, active-high levels `i1`/`i2`. It sits directly upstream of the two-input sequence controller and drives that controller's `i1`/`i2` inputs. It also emits single-cycle press and release pulses for logging and LEDs. Each channel runs its own four-state debounce FSM with a stability counter.

---
 rtl/debounce_pkg.sv | 15 +
 rtl/debounce_chan.sv | 109 ++++++++++
 rtl/key_debounce2.sv | 46 ++++
 tb/tb_key_debounce2.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the key debounce block.
// The 2-flop input synchronizer is enabled with the DEBOUNCE_SYNC_EN macro.
package debounce_pkg;

    // Gray-coded so that each legal transition flips a single state bit
    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b11,
        RELEASE_WAIT = 2'b10
    } db_state_t;

    localparam int DB_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: optional synchronizer, four-state FSM, stability counter, level and pulses.
// The synchronizer is present only when DEBOUNCE_SYNC_EN is defined.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      key_n,
    output logic      level,
    output logic      rise,
    output logic      fall,
    output db_state_t state
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic p;

`ifdef DEBOUNCE_SYNC_EN
    logic s1;
    logic s2;

    // Synchronizer resets to the released level so a held key looks like a fresh press
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= key_n;
            s2 <= s1;
        end
    end

    assign p = ~s2;
`else
    assign p = ~key_n;
`endif

    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Counter defaults to zero, so it is cleared on every WAIT entry and idles at 0
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (p) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!p) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!p) state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (p) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign state = state_q;

endmodule

// File: rtl/key_debounce2.sv
// Two independent key debounce channels feeding the sequence controller's i1/i2 inputs.
// Synchronizers are built only with DEBOUNCE_SYNC_EN defined; this module is wiring only.
module key_debounce2
    import debounce_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      key1_n,
    input  logic      key2_n,
    output logic      i1,
    output logic      i2,
    output logic      i1_rise,
    output logic      i2_rise,
    output logic      i1_fall,
    output logic      i2_fall,
    output db_state_t dbg_state1,
    output db_state_t dbg_state2
);

    debounce_chan #(
        .DB_CYCLES(DB_CYCLES)
    ) u_chan1 (
        .clk  (clk),
        .rst  (rst),
        .key_n(key1_n),
        .level(i1),
        .rise (i1_rise),
        .fall (i1_fall),
        .state(dbg_state1)
    );

    debounce_chan #(
        .DB_CYCLES(DB_CYCLES)
    ) u_chan2 (
        .clk  (clk),
        .rst  (rst),
        .key_n(key2_n),
        .level(i2),
        .rise (i2_rise),
        .fall (i2_fall),
        .state(dbg_state2)
    );

endmodule

// File: tb/tb_key_debounce2.sv
// Directed bench for key_debounce2 with DB_CYCLES = 8; expected output vectors are queued per edge.
// Latency follows DEBOUNCE_SYNC_EN: DB_CYCLES+3 with synchronizers, DB_CYCLES+1 without.
module tb_key_debounce2;
    import debounce_pkg::*;

    localparam int DB = 8;
`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = DB + 3;
`else
    localparam int LAT = DB + 1;
`endif

    logic      clk;
    logic      rst;
    logic      key1_n;
    logic      key2_n;
    logic      i1, i2, i1_rise, i2_rise, i1_fall, i2_fall;
    db_state_t dbg_state1, dbg_state2;

    logic [5:0] obs;
    logic [5:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    key_debounce2 #(.DB_CYCLES(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .key1_n    (key1_n),
        .key2_n    (key2_n),
        .i1        (i1),
        .i2        (i2),
        .i1_rise   (i1_rise),
        .i2_rise   (i2_rise),
        .i1_fall   (i1_fall),
        .i2_fall   (i2_fall),
        .dbg_state1(dbg_state1),
        .dbg_state2(dbg_state2)
    );

    assign obs = {i1, i1_rise, i1_fall, i2, i2_rise, i2_fall};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Queue n expected vectors; eN = edge of the level change (0 = none), lN = level before it
    task automatic push_window(input int n, input logic l1, input int e1,
                               input logic l2, input int e2);
        logic v1, v2;
        for (int k = 1; k <= n; k++) begin
            v1 = (e1 != 0 && k >= e1) ? ~l1 : l1;
            v2 = (e2 != 0 && k >= e2) ? ~l2 : l2;
            exp_q.push_back({v1, (e1 == k) && !l1, (e1 == k) && l1,
                             v2, (e2 == k) && !l2, (e2 == k) && l2});
        end
    endtask

    task automatic step(input string tag);
        logic [5:0] e;
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s obs=%b exp=<empty queue>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s obs=%b exp=%b", tag, obs, e);
            end
        end
    endtask

    task automatic check_now(input string tag, input logic [5:0] o, input logic [5:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s obs=%b exp=%b", tag, o, e);
        end
    endtask

    task automatic check_state(input string tag, input logic [1:0] o, input logic [1:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s obs=%b exp=%b", tag, o, e);
        end
    endtask

    initial begin
        rst    = 1'b0;
        key1_n = 1'b0;
        key2_n = 1'b1;

        // reset with key1 held
        push_window(3, 1'b0, 0, 1'b0, 0);
        repeat (3) step("in_reset");
        check_state("rst_state1", dbg_state1, IDLE);
        rst = 1'b1;
        push_window(LAT + 3, 1'b0, LAT, 1'b0, 0);
        repeat (LAT + 3) step("held_thru_reset");
        key1_n = 1'b1;
        push_window(LAT + 3, 1'b1, LAT, 1'b0, 0);
        repeat (LAT + 3) step("release_after_reset");

        // clean press held 20 cycles, then clean release
        key1_n = 1'b0;
        push_window(20, 1'b0, LAT, 1'b0, 0);
        repeat (20) step("clean_press");
        key1_n = 1'b1;
        push_window(LAT + 2, 1'b1, LAT, 1'b0, 0);
        repeat (LAT + 2) step("clean_release");

        // 5-cycle glitch is rejected
        push_window(20, 1'b0, 0, 1'b0, 0);
        for (int k = 1; k <= 20; k++) begin
            key1_n = (k <= 5) ? 1'b0 : 1'b1;
            step("glitch");
        end

        // bouncy release from PRESSED
        key1_n = 1'b0;
        push_window(LAT + 2, 1'b0, LAT, 1'b0, 0);
        repeat (LAT + 2) step("bounce_setup");
        push_window(12 + LAT + 2, 1'b1, 12 + LAT, 1'b0, 0);
        for (int k = 1; k <= 12 + LAT + 2; k++) begin
            key1_n = (k > 12) ? 1'b1 : ((((k - 1) / 3) % 2 == 0) ? 1'b1 : 1'b0);
            step("bouncy_release");
        end

        // both keys on the same cycle
        key1_n = 1'b0;
        key2_n = 1'b0;
        push_window(LAT + 2, 1'b0, LAT, 1'b0, LAT);
        repeat (LAT + 2) step("both_press");
        key1_n = 1'b1;
        key2_n = 1'b1;
        push_window(LAT + 2, 1'b1, LAT, 1'b1, LAT);
        repeat (LAT + 2) step("both_release");

        // key2 pressed two cycles after key1
        push_window(LAT + 4, 1'b0, LAT, 1'b0, LAT + 2);
        for (int k = 1; k <= LAT + 4; k++) begin
            key1_n = 1'b0;
            key2_n = (k >= 3) ? 1'b0 : 1'b1;
            step("staggered_press");
        end
        key1_n = 1'b1;
        key2_n = 1'b1;
        push_window(LAT + 2, 1'b1, LAT, 1'b1, LAT);
        repeat (LAT + 2) step("staggered_release");

        // reset mid-count: key2 already PRESSED, key1 counting at cnt = 5
        key2_n = 1'b0;
        push_window(LAT + 2, 1'b0, 0, 1'b0, LAT);
        repeat (LAT + 2) step("midrst_key2_setup");
        key1_n = 1'b0;
        push_window(LAT - 3, 1'b0, 0, 1'b1, 0);
        repeat (LAT - 3) step("midrst_count");
        check_state("midrst_wait1", dbg_state1, PRESS_WAIT);
        rst = 1'b0;
        #1;
        check_now("midrst_async", obs, 6'b000000);
        check_state("midrst_state1", dbg_state1, IDLE);
        check_state("midrst_state2", dbg_state2, IDLE);
        rst = 1'b1;
        push_window(LAT + 2, 1'b0, LAT, 1'b0, LAT);
        repeat (LAT + 2) step("midrst_rerise");

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain obs=%0d exp=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
